mux_scan_seq: RTL and testbench
===============================

# mux_scan_seq

Parametrised, registered N-channel by W-bit multiplexer with two modes: a direct single-channel read and an automatic scan across a channel-enable mask. It extends the team's combinational 16:1 bit-mux tree to multi-bit channels and a registered output with a valid/ready handshake. Each scan emits one sample per enabled channel, in ascending channel order, with no bubbles between samples. It sits between a bank of parallel sensor/data registers and a single serial consumer.

## Interface
- WIDTH, 16, bits per channel
- CHANNELS, 16, number of input channels (2..64, need not be a power of 2)
- SEL_W, $clog2(CHANNELS), derived select width (localparam, not overridable)

- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- ch_en  input  CHANNELS  scan enable mask, sampled only on an accepted start
- mode  input  1  0 = direct, 1 = scan; sampled only on an accepted start
- sel  input  SEL_W  channel for direct mode; sampled only on an accepted start
- start  input  1  request; accepted only in IDLE
- out_data  output  WIDTH  registered sample
- out_ch  output  SEL_W  channel index of out_data
- out_valid  output  1  out_data/out_ch are valid
- out_ready  input  1  consumer accepts when out_valid & out_ready
- busy  output  1  high in LOAD and DRAIN
- done  output  1  one-cycle pulse when an operation completes

## Operation
- Reset (async assert, sync release): state=IDLE. out_data=0, out_ch=0, out_valid=0, busy=0, done=0, mask register=0, pointer=0.
- Slot free = !out_valid | out_ready. A load writes out_data=in_data[ch], out_ch=ch, out_valid=1. in_data is sampled in the load cycle.
- IDLE, start=1, mode=0: load channel sel and go to DRAIN. If sel >= CHANNELS: out_data=0, out_ch=sel, and the transfer still happens.
- IDLE, start=1, mode=1, ch_en!=0: latch ch_en into the mask and load the lowest enabled channel.
  - If it is the only enabled channel: go to DRAIN.
  - Otherwise: go to LOAD, with the pointer set to the next enabled channel.
- IDLE, start=1, mode=1, ch_en=0: no load. Stay in IDLE; done=1 next cycle.
- LOAD: on each slot-free cycle, load the pointer channel and advance the pointer to the next higher enabled channel (priority search over the latched mask). Disabled channels cost no cycles. When the highest enabled channel is loaded, go to DRAIN.
- DRAIN: when out_valid & out_ready, clear out_valid, go to IDLE, and pulse done the next cycle.
- Handshake rules:
  - While out_valid & !out_ready, out_data and out_ch hold stable.
  - out_valid never drops without acceptance, except on reset.
- start is ignored outside IDLE. ch_en, mode and sel changes after acceptance have no effect.
- A start in the same cycle that done is high is accepted (state is IDLE).
- Reset mid-operation: immediate return to reset values. A pending sample is discarded and no done pulse is issued.

## Timing
- Start accepted at edge T: first out_valid=1 at T+1.
- With out_ready held high: one sample per cycle. A scan of K enabled channels shows out_valid at T+1..T+K, done=1 at T+K+1, busy=1 at T+1..T+K.
- Backpressure: each out_ready=0 cycle while valid stretches the sequence by exactly one cycle.
- Direct mode, out_ready=1: out_valid at T+1 only, done at T+2.
- Empty-mask scan: busy never rises; done at T+1.
- The output register is the only path from in_data to out_data; there is no combinational input-to-output path.

## Test plan
- Reset values and direct mode:
  - Stimulus: after reset, in_data channel c = 0x1000+c, mode=0, sel=5, start pulse, out_ready=1.
  - Response: out_data=0x1005 and out_ch=5 with out_valid one cycle after start; done two cycles after start; all outputs 0 during reset.
- Full scan:
  - Stimulus: ch_en=0xFFFF, mode=1, out_ready=1.
  - Response: out_ch 0..15 on 16 consecutive cycles, data 0x1000..0x100F; done on cycle 17; busy on cycles 1..16.
- Sparse mask with backpressure:
  - Stimulus: ch_en=0x8421, out_ready toggled 1,0,1,0,...
  - Response: out_ch sequence 0,5,10,15, each held stable through its stall cycle; no bubbles when ready=1; a single done after channel 15 is accepted.
- Boundaries:
  - Stimulus 1: ch_en=0 scan. Response: no out_valid; done one cycle after start.
  - Stimulus 2: CHANNELS=12, direct sel=13. Response: out_data=0, out_ch=13.
  - Stimulus 3: start pulsed while busy. Response: ignored, the sequence is unchanged.
- Mid-scan changes:
  - Stimulus: change ch_en to 0x0001 and sel mid-scan.
  - Response: the scan follows the original mask.
- Reset mid-scan:
  - Stimulus: assert rst_n low asynchronously during a stalled sample of a 0xFFFF scan.
  - Response: out_valid drops immediately, no done; after release, a new start scans from channel 0.

Source files
------------

// File: rtl/mux_scan_seq_if.sv
// rtl/mux_scan_seq_if.sv - request/sample bundle for the registered scan multiplexer
//   in_data   : CHANNELS*WIDTH packed channel bank, channel c at [c*WIDTH +: WIDTH]
//   ch_en     : scan enable mask (latched on an accepted start)
//   mode      : 0 = direct read of sel, 1 = scan over ch_en
//   sel       : direct-mode channel
//   start     : operation request, accepted only when idle
//   out_data  : registered sample
//   out_ch    : channel index of out_data
//   out_valid : sample valid
//   out_ready : consumer accepts when out_valid & out_ready
//   busy      : operation in progress
//   done      : one-cycle completion pulse
interface mux_scan_seq_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       ch_en;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic                      start;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_ch;
  logic                      out_valid;
  logic                      out_ready;
  logic                      busy;
  logic                      done;

  modport master (
    output in_data, ch_en, mode, sel, start, out_ready,
    input  out_data, out_ch, out_valid, busy, done
  );

  modport slave (
    input  in_data, ch_en, mode, sel, start, out_ready,
    output out_data, out_ch, out_valid, busy, done
  );
endinterface

// File: rtl/mux_scan_seq.sv
// rtl/mux_scan_seq.sv - registered N-channel mux with direct read and masked ascending scan
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   bus     : mux_scan_seq_if slave (request inputs, registered sample output + handshake)
module mux_scan_seq #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mux_scan_seq_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CHANNELS-1:0]  r_mask;
  logic [SEL_W-1:0]     r_ptr;
  logic [WIDTH-1:0]     r_out_data;
  logic [SEL_W-1:0]     r_out_ch;
  logic                 r_out_valid;
  logic                 r_done;

  logic                 w_slot_free;
  logic                 w_load;
  logic [SEL_W-1:0]     w_load_ch;
  logic [WIDTH-1:0]     w_load_data;
  logic [SEL_W-1:0]     w_ptr_nxt;
  logic                 w_mask_ld;
  logic                 w_done_nxt;
  logic                 w_clr_valid;
  logic [SEL_W:0]       w_first;
  logic [SEL_W:0]       w_second;
  logic [SEL_W:0]       w_adv;

  // Lowest set bit of m at index >= lo; MSB of the result flags "found".
  function automatic logic [SEL_W:0] f_next_set(input logic [CHANNELS-1:0] m, input int lo);
    logic [SEL_W:0] v;
    v = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (m[c] && (c >= lo)) v = {1'b1, SEL_W'(c)};
    end
    return v;
  endfunction

  assign w_first     = f_next_set(bus.ch_en, 0);
  assign w_second    = f_next_set(bus.ch_en, int'(w_first[SEL_W-1:0]) + 1);
  assign w_adv       = f_next_set(r_mask, int'(r_ptr) + 1);
  assign w_slot_free = !r_out_valid || bus.out_ready;

  // Selects that match no channel (sel >= CHANNELS) leave the sample at zero.
  always_comb begin
    w_load_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_load_ch == SEL_W'(c)) w_load_data = bus.in_data[c*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_ch   = r_ptr;
    w_ptr_nxt   = r_ptr;
    w_mask_ld   = 1'b0;
    w_done_nxt  = 1'b0;
    w_clr_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (!bus.mode) begin
            w_load      = 1'b1;
            w_load_ch   = bus.sel;
            w_state_nxt = S_DRAIN;
          end else if (w_first[SEL_W]) begin
            w_load      = 1'b1;
            w_load_ch   = w_first[SEL_W-1:0];
            w_mask_ld   = 1'b1;
            if (w_second[SEL_W]) begin
              w_ptr_nxt   = w_second[SEL_W-1:0];
              w_state_nxt = S_LOAD;
            end else begin
              w_state_nxt = S_DRAIN;
            end
          end else begin
            // Empty scan: nothing to emit, report completion straight away.
            w_done_nxt = 1'b1;
          end
        end
      end
      S_LOAD: begin
        // r_ptr always names a pending enabled channel while in LOAD.
        if (w_slot_free) begin
          w_load    = 1'b1;
          w_load_ch = r_ptr;
          if (w_adv[SEL_W]) w_ptr_nxt = w_adv[SEL_W-1:0];
          else              w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_out_valid && bus.out_ready) begin
          w_clr_valid = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_ptr       <= '0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_done  <= w_done_nxt;
      if (w_mask_ld) r_mask <= bus.ch_en;
      if (w_load) begin
        r_out_data  <= w_load_data;
        r_out_ch    <= w_load_ch;
        r_out_valid <= 1'b1;
      end else if (w_clr_valid) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
endmodule

// File: tb/tb_mux_scan_seq.sv
// tb/tb_mux_scan_seq.sv - self-checking bench for mux_scan_seq
module tb_mux_scan_seq;
  localparam int W  = 16;
  localparam int CH = 16;
  localparam int SW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_scan_seq_if #(.WIDTH(W), .CHANNELS(CH)) bus ();
  mux_scan_seq_if #(.WIDTH(W), .CHANNELS(12)) bus12 ();

  mux_scan_seq #(.WIDTH(W), .CHANNELS(CH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  mux_scan_seq #(.WIDTH(W), .CHANNELS(12)) dut12 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus12)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] mem [CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem();
    for (int c = 0; c < CH; c++) bus.in_data[c*W +: W] = mem[c];
  endtask

  // Reference: a scan emits the enabled channels in ascending order; direct emits sel.
  // Each emitted sample stays on the output until a ready cycle consumes it, and done
  // follows the cycle after the last acceptance (or right after start on an empty scan).
  task automatic do_op(input logic m, input logic [CH-1:0] msk, input logic [SW-1:0] s,
                       input int rdy_kind, input bit perturb);
    int q[$];
    int budget;
    bit rdy;
    bit tog;
    if (!m) q.push_back(int'(s));
    else for (int c = 0; c < CH; c++) if (msk[c]) q.push_back(c);
    bus.mode  = m;
    bus.ch_en = msk;
    bus.sel   = s;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    budget = 0;
    tog    = 1'b1;
    while (q.size() > 0 && budget < 200) begin
      chk("valid", 32'(bus.out_valid), 32'd1);
      chk("out_ch", 32'(bus.out_ch), q[0]);
      chk("out_data", 32'(bus.out_data), 32'(mem[q[0]]));
      chk("busy", 32'(bus.busy), 32'd1);
      chk("done_early", 32'(bus.done), 32'd0);
      case (rdy_kind)
        0:       rdy = 1'b1;
        1:       begin rdy = tog; tog = !tog; end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = rdy;
      if (perturb) begin
        bus.start = 1'b1;
        bus.ch_en = 16'h0001;
        bus.sel   = SW'($urandom);
        bus.mode  = 1'($urandom);
      end
      tick();
      if (rdy) void'(q.pop_front());
      budget++;
    end
    bus.start = 1'b0;
    chk("in_budget", 32'(budget < 200), 32'd1);
    chk("done", 32'(bus.done), 32'd1);
    chk("valid_end", 32'(bus.out_valid), 32'd0);
    chk("busy_end", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.in_data     = '0;
    bus.ch_en       = '0;
    bus.mode        = 1'b0;
    bus.sel         = '0;
    bus.start       = 1'b0;
    bus.out_ready   = 1'b1;
    bus12.in_data   = '0;
    bus12.ch_en     = '0;
    bus12.mode      = 1'b0;
    bus12.sel       = '0;
    bus12.start     = 1'b0;
    bus12.out_ready = 1'b1;
    for (int c = 0; c < CH; c++) mem[c] = W'(16'h1000 + c);
    load_mem();

    // Reset values
    tick();
    tick();
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_ch", 32'(bus.out_ch), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Direct read of channel 5
    do_op(1'b0, 16'h0000, 4'd5, 0, 1'b0);
    // Full scan, back-to-back start in the done cycle
    do_op(1'b1, 16'hFFFF, 4'd0, 0, 1'b0);
    // Sparse mask with alternating ready, then exactly one done pulse
    do_op(1'b1, 16'h8421, 4'd0, 1, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    chk("single_done", 32'(bus.done), 32'd0);
    // Empty-mask scan
    do_op(1'b1, 16'h0000, 4'd0, 0, 1'b0);
    // Start/ch_en/sel/mode wiggled mid-scan must be ignored
    do_op(1'b1, 16'hA5C3, 4'd0, 2, 1'b1);

    // Out-of-range direct select on a 12-channel instance
    tick();
    for (int c = 0; c < 12; c++) bus12.in_data[c*W +: W] = W'(16'hBEE0 + c);
    bus12.sel   = 4'd13;
    bus12.start = 1'b1;
    tick();
    bus12.start = 1'b0;
    chk("oor_data", 32'(bus12.out_data), 32'd0);
    chk("oor_ch", 32'(bus12.out_ch), 32'd13);
    chk("oor_valid", 32'(bus12.out_valid), 32'd1);
    tick();
    chk("oor_done", 32'(bus12.done), 32'd1);
    chk("oor_valid_end", 32'(bus12.out_valid), 32'd0);

    // Randomized operations against the reference model
    for (int i = 0; i < 15; i++) begin
      logic [CH-1:0] msk;
      for (int c = 0; c < CH; c++) mem[c] = W'($urandom);
      load_mem();
      msk = CH'($urandom & $urandom);
      do_op(1'($urandom), msk, SW'($urandom), 2, 1'($urandom));
    end

    // Reset in the middle of a stalled sample
    bus.out_ready = 1'b1;
    tick();
    bus.mode  = 1'b1;
    bus.ch_en = 16'hFFFF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("pre_rst_ch", 32'(bus.out_ch), 32'd2);
    bus.out_ready = 1'b0;
    tick();
    chk("stall_ch", 32'(bus.out_ch), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_ch", 32'(bus.out_ch), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("post_rst_done", 32'(bus.done), 32'd0);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    do_op(1'b1, 16'hFFFF, 4'd0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
